// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//   Microwave oven cook-timer controller. Digits are entered on a keypad
//   in IDLE, shifting in from the right. start begins cooking, and each
//   1 Hz tick counts the MM:SS time down. The door or stop/clear pauses
//   cooking. Reaching 00:00 ends in DONE.
//
// Ports
//   clk           in   system clock, rising edge active
//   reset         in   asynchronous active-low reset
//   tick_1hz      in   one-clk pulse per second
//   key_valid     in   one-clk keypad strobe
//   key_digit     in   [3:0] keypad value, sampled with key_valid
//   start         in   one-clk start request
//   stop_clear    in   one-clk stop/clear request
//   door_closed   in   level, 1 = door closed
//   min_tens      out  [2:0] BCD minutes tens (0-5)
//   min_ones      out  [3:0] BCD minutes ones (0-9)
//   sec_tens      out  [2:0] BCD seconds tens (0-5)
//   sec_ones      out  [3:0] BCD seconds ones (0-9)
//   state         out  [1:0] IDLE=0 RUN=1 PAUSE=2 DONE=3
//   magnetron_on  out  1 while cooking (decoded from the state register)
//   done          out  1 while in DONE (decoded from the state register)
// -----------------------------------------------------------------------------
module microwave_timer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       magnetron_on,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] min_tens_r, min_tens_s;
  logic [3:0] min_ones_r, min_ones_s;
  logic [2:0] sec_tens_r, sec_tens_s;
  logic [3:0] sec_ones_r, sec_ones_s;
  logic       is_zero_s;
  logic       is_one_s;
  logic       key_ok_s;

  // One-second BCD decrement with a borrow chain. The caller guarantees the
  // time is non-zero, so min_tens never underflows.
  function automatic logic [13:0] dec_time(input logic [2:0] mt, input logic [3:0] mo,
                                           input logic [2:0] st, input logic [3:0] so);
    logic [2:0] mt_v;
    logic [3:0] mo_v;
    logic [2:0] st_v;
    logic [3:0] so_v;
    mt_v = mt;
    mo_v = mo;
    st_v = st;
    so_v = so;
    if (so != 4'd0) begin
      so_v = so - 4'd1;
    end else begin
      so_v = 4'd9;
      if (st != 3'd0) begin
        st_v = st - 3'd1;
      end else begin
        st_v = 3'd5;
        if (mo != 4'd0) begin
          mo_v = mo - 4'd1;
        end else begin
          mo_v = 4'd9;
          mt_v = mt - 3'd1;
        end
      end
    end
    return {mt_v, mo_v, st_v, so_v};
  endfunction

  // Time-value decodes used by the next-state logic.
  always_comb begin
    is_zero_s = (min_tens_r == 3'd0) && (min_ones_r == 4'd0) &&
                (sec_tens_r == 3'd0) && (sec_ones_r == 4'd0);
    is_one_s  = (min_tens_r == 3'd0) && (min_ones_r == 4'd0) &&
                (sec_tens_r == 3'd0) && (sec_ones_r == 4'd1);
    // A key is taken only if every digit stays in range after the shift.
    key_ok_s  = (key_digit <= 4'd9) && (sec_ones_r <= 4'd5) && (min_ones_r <= 4'd5);
  end

  // Next-state and next-time logic. Inputs are tested in fixed priority order
  // (door open, stop_clear, start, tick, key). The first one that applies wins.
  always_comb begin
    state_s    = state_r;
    min_tens_s = min_tens_r;
    min_ones_s = min_ones_r;
    sec_tens_s = sec_tens_r;
    sec_ones_s = sec_ones_r;
    case (state_r)
      ST_IDLE: begin
        if (!door_closed) begin
          state_s = ST_IDLE;
        end else if (stop_clear) begin
          {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} = 14'd0;
        end else if (start) begin
          state_s = ST_RUN;
          if (is_zero_s) begin
            sec_tens_s = 3'd3;
          end else begin
            sec_tens_s = sec_tens_r;
          end
        end else if (tick_1hz) begin
          state_s = ST_IDLE;
        end else if (key_valid && key_ok_s) begin
          min_tens_s = min_ones_r[2:0];
          min_ones_s = {1'b0, sec_tens_r};
          sec_tens_s = sec_ones_r[2:0];
          sec_ones_s = key_digit;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!door_closed || stop_clear) begin
          state_s = ST_PAUSE;
        end else if (start) begin
          state_s = ST_RUN;
        end else if (tick_1hz) begin
          // 00:00 cannot normally be running. If it is, finish rather than wrap.
          if (is_zero_s) begin
            state_s = ST_DONE;
          end else begin
            {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} =
              dec_time(min_tens_r, min_ones_r, sec_tens_r, sec_ones_r);
            if (is_one_s) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RUN;
            end
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (!door_closed) begin
          state_s = ST_PAUSE;
        end else if (stop_clear) begin
          state_s = ST_IDLE;
          {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} = 14'd0;
        end else if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} = 14'd0;
        if (!door_closed || stop_clear) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} = 14'd0;
      end
    endcase
  end

  // State and digit registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      min_tens_r <= 3'd0;
      min_ones_r <= 4'd0;
      sec_tens_r <= 3'd0;
      sec_ones_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      min_tens_r <= min_tens_s;
      min_ones_r <= min_ones_s;
      sec_tens_r <= sec_tens_s;
      sec_ones_r <= sec_ones_s;
    end
  end

  // Output mapping. The two status flags decode straight off the state
  // register, so reset drops them at once.
  always_comb begin
    min_tens     = min_tens_r;
    min_ones     = min_ones_r;
    sec_tens     = sec_tens_r;
    sec_ones     = sec_ones_r;
    state        = state_r;
    magnetron_on = (state_r == ST_RUN);
    done         = (state_r == ST_DONE);
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microwave_timer_ctrl
//   Directed bench for microwave_timer_ctrl. The reference model keeps the
//   time as a plain count of seconds and derives the digits from it. A
//   negedge compare process checks every cycle, and literal checks pin the
//   key scenarios.
// -----------------------------------------------------------------------------
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop_clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] state;
  logic       magnetron_on;
  logic       done;

  int total = 0;
  int bad = 0;

  microwave_timer_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
    .door_closed(door_closed), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .state(state),
    .magnetron_on(magnetron_on), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: time as total seconds ----------------
  int m_state = 0;   // 0 idle, 1 run, 2 pause, 3 done
  int m_secs  = 0;

  always @(posedge clk or negedge reset) begin
    int ns, nt, mt, mo, st, so;
    if (!reset) begin
      m_state <= 0;
      m_secs  <= 0;
    end else begin
      ns = m_state;
      nt = m_secs;
      mt = m_secs / 600;
      mo = (m_secs / 60) % 10;
      st = (m_secs % 60) / 10;
      so = m_secs % 10;
      if (m_state == 0) begin
        if (!door_closed) ;
        else if (stop_clear) nt = 0;
        else if (start) begin
          ns = 1;
          if (m_secs == 0) nt = 30;
        end
        else if (tick_1hz) ;
        else if (key_valid && key_digit <= 9 && so <= 5 && mo <= 5)
          nt = (mo * 10 + st) * 60 + so * 10 + int'(key_digit);
      end else if (m_state == 1) begin
        if (!door_closed || stop_clear) ns = 2;
        else if (start) ;
        else if (tick_1hz) begin
          if (m_secs > 0) nt = m_secs - 1;
          if (nt == 0) ns = 3;
        end
      end else if (m_state == 2) begin
        if (!door_closed) ;
        else if (stop_clear) begin ns = 0; nt = 0; end
        else if (start) ns = 1;
      end else begin
        nt = 0;
        if (!door_closed || stop_clear) ns = 0;
      end
      m_state <= ns;
      m_secs  <= nt;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("m_state",   int'(state), m_state);
    check("m_min_tens", int'(min_tens), m_secs / 600);
    check("m_min_ones", int'(min_ones), (m_secs / 60) % 10);
    check("m_sec_tens", int'(sec_tens), (m_secs % 60) / 10);
    check("m_sec_ones", int'(sec_ones), m_secs % 10);
    check("m_magnetron", int'(magnetron_on), (m_state == 1) ? 1 : 0);
    check("m_done",     int'(done), (m_state == 3) ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic tk, input logic kv, input logic [3:0] kd,
                      input logic st, input logic sc);
    tick_1hz = tk; key_valid = kv; key_digit = kd; start = st; stop_clear = sc;
    @(negedge clk);
    tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop_clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic expect_time(input string name, input int mt, input int mo,
                             input int st, input int so);
    check({name, "_mt"}, int'(min_tens), mt);
    check({name, "_mo"}, int'(min_ones), mo);
    check({name, "_st"}, int'(sec_tens), st);
    check({name, "_so"}, int'(sec_ones), so);
  endtask

  initial begin
    #3;
    check("rst_state", int'(state), 0);
    check("rst_mag", int'(magnetron_on), 0);
    expect_time("rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Entry and key rejection.
    key(4'd1); key(4'd3); key(4'd0);
    expect_time("entry130", 0, 1, 3, 0);
    key(4'd7);
    expect_time("entry1307", 1, 3, 0, 7);
    key(4'd12);
    expect_time("key12", 1, 3, 0, 7);
    key(4'd1);
    expect_time("key_so7", 1, 3, 0, 7);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    expect_time("clear", 0, 0, 0, 0);

    // Countdown from 01:01.
    key(4'd1); key(4'd0); key(4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("cd_run", int'(state), 1);
    expect_time("cd_start", 0, 1, 0, 1);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("cd1", 0, 1, 0, 0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("cd2", 0, 0, 5, 9);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("cd3", 0, 0, 5, 8);
    check("cd_mag", int'(magnetron_on), 1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("cd_pause", int'(state), 2);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("cd_idle", int'(state), 0);

    // Completion from 00:02.
    key(4'd2);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("cmp1", 0, 0, 0, 1);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("cmp0", 0, 0, 0, 0);
    check("cmp_state", int'(state), 3);
    check("cmp_done", int'(done), 1);
    check("cmp_mag", int'(magnetron_on), 0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    check("done_ign", int'(state), 3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("cmp_idle", int'(state), 0);
    check("cmp_done0", int'(done), 0);

    // Door interaction at 00:45.
    key(4'd4); key(4'd5);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    door_closed = 1'b0;
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("door_pause", int'(state), 2);
    expect_time("door_hold", 0, 0, 4, 5);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("door_start_ign", int'(state), 2);
    door_closed = 1'b1;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("door_resume", int'(state), 1);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("door_tick", 0, 0, 4, 4);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    expect_time("door_clr", 0, 0, 0, 0);

    // Quick start, with a tick on the entry edge that must not count.
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    check("qs_run", int'(state), 1);
    expect_time("qs30", 0, 0, 3, 0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("qs_pause", int'(state), 2);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("qs_hold", 0, 0, 3, 0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("qs_idle", int'(state), 0);
    expect_time("qs_clr", 0, 0, 0, 0);

    // Full borrow chain 10:00 -> 09:59.
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    expect_time("b1000", 1, 0, 0, 0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    expect_time("b0959", 0, 9, 5, 9);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // DONE left by opening the door.
    key(4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check("dd_done", int'(state), 3);
    door_closed = 1'b0;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("dd_idle", int'(state), 0);
    door_closed = 1'b1;
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN at 05:17.
    key(4'd5); key(4'd1); key(4'd7);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("rr_mag1", int'(magnetron_on), 1);
    expect_time("rr517", 0, 5, 1, 7);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rr_state", int'(state), 0);
    check("rr_mag0", int'(magnetron_on), 0);
    check("rr_done0", int'(done), 0);
    expect_time("rr_time", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    key(4'd3);
    expect_time("post_rst", 0, 0, 0, 3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
